// File: rtl/clk_pkg.sv
// Shared clocking definitions: controller states and the
// smallest legal divide ratio.
package clk_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PEND,
    STOP
  } clk_state_t;

  localparam int DIV_MIN = 2;

endpackage

// File: rtl/clk_div_ctrl.sv
// Runtime-programmable clock divider with glitch-free ratio
// changes at period boundaries and clean run/stop draining.
module clk_div_ctrl
  import clk_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int DIV_RST = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_run,
  input  logic             i_cfg_valid,
  input  logic [CNT_W-1:0] i_cfg_div,
  output logic             o_cfg_ready,
  output logic             o_cfg_err,
  output logic [CNT_W-1:0] o_div_cur,
  output logic             o_clk_div,
  output logic             o_tick_rise,
  output logic             o_tick_fall,
  output logic             o_busy
);

  localparam logic [CNT_W-1:0] DMIN = CNT_W'(DIV_MIN);
  localparam logic [CNT_W-1:0] DRST = CNT_W'(DIV_RST);

  clk_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] cfg_clamp;
  logic [CNT_W:0]   hi_d;
  logic             xfer, wrap, active_d;
  logic             err_d, clk_d, rise_d, fall_d;
  logic             err_q, clk_q, rise_q, fall_q;

  assign o_cfg_ready = (state_q == IDLE) || (state_q == RUN);
  assign o_busy      = (state_q != IDLE);
  assign o_cfg_err   = err_q;
  assign o_div_cur   = div_q;
  assign o_clk_div   = clk_q;
  assign o_tick_rise = rise_q;
  assign o_tick_fall = fall_q;

  assign xfer      = i_cfg_valid && o_cfg_ready;
  assign cfg_clamp = (i_cfg_div < DMIN) ? DMIN : i_cfg_div;
  assign wrap      = (cnt_q == (div_q - CNT_W'(1)));
  assign cnt_inc   = wrap ? '0 : cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    pend_d  = pend_q;
    err_d   = xfer && (i_cfg_div < DMIN);
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (xfer) div_d = cfg_clamp;
        if (i_run) state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt_inc;
        if (xfer) begin
          pend_d  = cfg_clamp;
          state_d = PEND;
        end else if (!i_run) begin
          state_d = STOP;
        end
      end
      PEND: begin
        cnt_d = cnt_inc;
        if (wrap) begin
          div_d   = pend_q;
          state_d = i_run ? RUN : IDLE;
        end
      end
      STOP: begin
        cnt_d = cnt_inc;
        if (i_run) state_d = RUN;
        else if (wrap) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from next-cycle counter and ratio,
  // so each strobe lines up with the cycle its count is held.
  assign hi_d     = ({1'b0, div_d} + (CNT_W+1)'(1)) >> 1;
  assign active_d = (state_d != IDLE);
  assign clk_d    = active_d && ({1'b0, cnt_d} < hi_d);
  assign rise_d   = active_d && (cnt_d == '0);
  assign fall_d   = active_d && ({1'b0, cnt_d} == hi_d);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= DRST;
      pend_q  <= DRST;
      err_q   <= 1'b0;
      clk_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
      clk_q   <= clk_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Bench for clk_div_ctrl: directed scenarios plus random traffic
// checked every cycle against a period-level reference model.
module tb_clk_div_ctrl;

  localparam int CNT_W   = 8;
  localparam int DIV_RST = 2;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_PEND = 2;
  localparam int M_STOP = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             run = 1'b0;
  logic             cfg_valid = 1'b0;
  logic [CNT_W-1:0] cfg_div = '0;
  logic             cfg_ready, cfg_err, clk_div;
  logic             tick_rise, tick_fall, busy;
  logic [CNT_W-1:0] div_cur;

  int n_cmp = 0;
  int n_bad = 0;

  int m_mode, m_pos, m_n, m_pend;
  bit m_err;

  clk_div_ctrl #(.CNT_W(CNT_W), .DIV_RST(DIV_RST)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_run       (run),
    .i_cfg_valid (cfg_valid),
    .i_cfg_div   (cfg_div),
    .o_cfg_ready (cfg_ready),
    .o_cfg_err   (cfg_err),
    .o_div_cur   (div_cur),
    .o_clk_div   (clk_div),
    .o_tick_rise (tick_rise),
    .o_tick_fall (tick_fall),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_mode = M_IDLE;
    m_pos  = 0;
    m_n    = DIV_RST;
    m_pend = DIV_RST;
    m_err  = 0;
  endfunction

  // One reference-clock step, reasoned per period: either we are
  // inside a period or at its last cycle, where decisions land.
  function automatic void model_update();
    bit xfer;
    int req;
    xfer  = cfg_valid && (m_mode == M_IDLE || m_mode == M_RUN);
    req   = (int'(cfg_div) < 2) ? 2 : int'(cfg_div);
    m_err = xfer && (int'(cfg_div) < 2);
    if (m_mode == M_IDLE) begin
      if (xfer) m_n = req;
      m_pos = 0;
      if (run) m_mode = M_RUN;
    end else if (m_pos + 1 < m_n) begin
      m_pos++;
      if (m_mode == M_RUN && xfer) begin
        m_pend = req;
        m_mode = M_PEND;
      end else if (m_mode == M_RUN && !run) m_mode = M_STOP;
      else if (m_mode == M_STOP && run) m_mode = M_RUN;
    end else begin
      m_pos = 0;
      if (m_mode == M_RUN) begin
        if (xfer) begin
          m_pend = req;
          m_mode = M_PEND;
        end else if (!run) m_mode = M_STOP;
      end else if (m_mode == M_PEND) begin
        m_n    = m_pend;
        m_mode = run ? M_RUN : M_IDLE;
      end else begin
        m_mode = run ? M_RUN : M_IDLE;
      end
    end
  endfunction

  task automatic check_all();
    int hi;
    bit act;
    hi  = (m_n + 1) / 2;
    act = (m_mode != M_IDLE);
    chk("clk_div", 32'(clk_div), 32'(act && m_pos < hi));
    chk("tick_rise", 32'(tick_rise), 32'(act && m_pos == 0));
    chk("tick_fall", 32'(tick_fall), 32'(act && m_pos == hi));
    chk("cfg_ready", 32'(cfg_ready),
        32'(m_mode == M_IDLE || m_mode == M_RUN));
    chk("busy", 32'(busy), 32'(act));
    chk("div_cur", 32'(div_cur), 32'(m_n));
    chk("cfg_err", 32'(cfg_err), 32'(m_err));
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  task automatic cycles(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_pos(input int p, input int budget);
    int k;
    k = 0;
    while (!(m_mode != M_IDLE && m_pos == p) && k < budget) begin
      tick();
      k++;
    end
    chk("wait_pos", 32'(k < budget), 32'd1);
  endtask

  initial begin
    int hc;
    int k;
    model_reset();
    #12;
    check_all();
    chk("rst_div", 32'(div_cur), 32'(DIV_RST));
    chk("rst_ready", 32'(cfg_ready), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    cycles(2);

    // start with reset ratio 2
    run = 1'b1;
    tick();
    chk("start_clk", 32'(clk_div), 32'd1);
    chk("start_rise", 32'(tick_rise), 32'd1);
    cycles(5);

    // program 5 at cnt 1
    wait_pos(1, 10);
    cfg_valid = 1'b1;
    cfg_div   = 8'd5;
    tick();
    cfg_valid = 1'b0;
    chk("pend_ready", 32'(cfg_ready), 32'd0);
    cycles(12);
    chk("div5", 32'(div_cur), 32'd5);

    // ratio 4, then drop run at cnt 1
    wait_pos(0, 10);
    cfg_valid = 1'b1;
    cfg_div   = 8'd4;
    tick();
    cfg_valid = 1'b0;
    cycles(12);
    wait_pos(1, 10);
    run = 1'b0;
    cycles(3);
    chk("stop_busy", 32'(busy), 32'd0);
    chk("stop_clk", 32'(clk_div), 32'd0);
    cycles(3);

    // ratio 0 in IDLE gets clamped
    cfg_valid = 1'b1;
    cfg_div   = 8'd0;
    tick();
    cfg_valid = 1'b0;
    chk("err_pulse", 32'(cfg_err), 32'd1);
    chk("err_div", 32'(div_cur), 32'd2);
    tick();
    chk("err_once", 32'(cfg_err), 32'd0);

    // ratio 255 accepted together with start
    cfg_valid = 1'b1;
    cfg_div   = 8'd255;
    run       = 1'b1;
    tick();
    cfg_valid = 1'b0;
    chk("n255_div", 32'(div_cur), 32'd255);
    hc = int'(clk_div);
    repeat (254) begin
      tick();
      hc += int'(clk_div);
    end
    chk("n255_high", 32'(hc), 32'd128);
    tick();
    chk("n255_wrap", 32'(tick_rise), 32'd1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      run       = ($urandom_range(0, 9) != 0);
      cfg_valid = ($urandom_range(0, 5) == 0);
      cfg_div   = CNT_W'($urandom_range(0, 12));
      tick();
    end

    // reset while a ratio is pending
    run       = 1'b1;
    cfg_valid = 1'b0;
    k = 0;
    while (!(m_mode == M_RUN) && k < 600) begin
      tick();
      k++;
    end
    chk("reach_run", 32'(k < 600), 32'd1);
    cfg_valid = 1'b1;
    cfg_div   = 8'd9;
    tick();
    cfg_valid = 1'b0;
    chk("pend_ready2", 32'(cfg_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_div", 32'(div_cur), 32'(DIV_RST));
    @(negedge clk) rst_n = 1'b1;
    cycles(6);
    chk("post_rst_div", 32'(div_cur), 32'(DIV_RST));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
